// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULU = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    case (op)
      ALU_MULU, ALU_DIVU, ALU_REMU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine, one bit per cycle.
// res carries the value after the step being taken while done is high.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [CNTW-1:0]  cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;

  logic [WIDTH:0]   acc_nx_s;
  logic [WIDTH-1:0] x_nx_s;
  logic [WIDTH-1:0] y_nx_s;
  logic [WIDTH:0]   rem_sh_s;

  // One iteration step: acc/x/y are product/multiplicand/multiplier or remainder/quotient/divisor
  always_comb begin
    acc_nx_s = acc_r;
    x_nx_s   = x_r;
    y_nx_s   = y_r;
    rem_sh_s = {acc_r[WIDTH-1:0], x_r[WIDTH-1]};
    if (op_r == ALU_MULU) begin
      acc_nx_s = {1'b0, acc_r[WIDTH-1:0] + (y_r[0] ? x_r : {WIDTH{1'b0}})};
      x_nx_s   = {x_r[WIDTH-2:0], 1'b0};
      y_nx_s   = {1'b0, y_r[WIDTH-1:1]};
    end else if (rem_sh_s >= {1'b0, y_r}) begin
      // b==0 always subtracts: quotient fills with ones and remainder ends as a
      acc_nx_s = rem_sh_s - {1'b0, y_r};
      x_nx_s   = {x_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx_s = rem_sh_s;
      x_nx_s   = {x_r[WIDTH-2:0], 1'b0};
    end
  end

  // Result selection from the post-step values
  always_comb begin
    res = {WIDTH{1'b0}};
    case (op_r)
      ALU_MULU: res = acc_nx_s[WIDTH-1:0];
      ALU_DIVU: res = x_nx_s;
      ALU_REMU: res = acc_nx_s[WIDTH-1:0];
      default:  res = {WIDTH{1'b0}};
    endcase
  end

  assign done = (cnt_r == CNTW'(1));

  // Operand load on start, then one step per cycle until the counter drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNTW{1'b0}};
      op_r  <= 4'b0000;
      acc_r <= {(WIDTH+1){1'b0}};
      x_r   <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
    end else if (start) begin
      cnt_r <= CNTW'(WIDTH);
      op_r  <= op;
      acc_r <= {(WIDTH+1){1'b0}};
      x_r   <= a;
      y_r   <= b;
    end else if (cnt_r != {CNTW{1'b0}}) begin
      cnt_r <= cnt_r - CNTW'(1);
      acc_r <= acc_nx_s;
      x_r   <= x_nx_s;
      y_r   <= y_nx_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/add/sub/nor,
// iterative unsigned MULU/DIVU/REMU via alu_muldiv_iter.
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_nx;
  logic             zero_r;
  logic [WIDTH-1:0] single_s;
  logic             start_s;
  logic             done_s;
  logic [WIDTH-1:0] res_s;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .op    (alu_op),
    .a     (a),
    .b     (b),
    .done  (done_s),
    .res   (res_s)
  );

  // Single-cycle datapath; unknown opcodes yield zero
  always_comb begin
    single_s = {WIDTH{1'b0}};
    case (alu_op)
      ALU_AND: single_s = a & b;
      ALU_OR:  single_s = a | b;
      ALU_ADD: single_s = a + b;
      ALU_SUB: single_s = a - b;
      ALU_NOR: single_s = ~(a | b);
      default: single_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state, engine start and result capture
  always_comb begin
    state_nx  = state_r;
    start_s   = 1'b0;
    result_nx = result_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && is_multicycle(alu_op)) begin
          start_s  = 1'b1;
          state_nx = ST_BUSY;
        end else if (in_valid) begin
          result_nx = single_s;
          state_nx  = ST_DONE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          result_nx = res_s;
          state_nx  = ST_DONE;
        end else begin
          state_nx = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, result and zero registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b1;
    end else begin
      state_r  <= state_nx;
      result_r <= result_nx;
      zero_r   <= (result_nx == {WIDTH{1'b0}});
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign result    = result_r;
  assign zero      = zero_r;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU that replaces the purely combinational 64-bit ALU in the execute stage.
- Keeps the single-cycle logic/add/sub/nor operations with the same 4-bit opcode encoding.
- Adds iterative unsigned multiply, divide and remainder.
- Uses a valid/ready handshake on both sides so the pipeline can stall while a long operation runs.

Parameters:
- WIDTH, 64, operand and result width in bits; legal range is 2 or more.
- CNTW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and opcode are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  4  operation select
- out_valid  output  1  result and zero are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- zero  output  1  registered flag; 1 when result==0
- busy  output  1  high in BUSY or DONE state

Behaviour:
- Reset is asynchronous and active-high; it is the only reset. It forces:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; zero=1; counter=0.
- Reset mid-operation aborts the operation silently. No partial result is ever presented.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR: single-cycle.
  - 1000 MULU: low WIDTH bits of a*b.
  - 1001 DIVU: a/b, unsigned.
  - 1010 REMU: a%b, unsigned.
  - Any other opcode: result=0, zero=1, completes as single-cycle.
- Arithmetic wraps modulo 2^WIDTH. No carry or overflow output.
- Accept occurs on a rising edge with in_valid && in_ready. a, b and alu_op are captured at that edge; later input changes are ignored.
- in_ready = (state==IDLE). There is no accept in the same cycle as result handoff; throughput for single-cycle ops is one op per 2 cycles.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of single-cycle op: compute, register result/zero, go to DONE. out_valid is high in the cycle after the accept edge (latency 1).
  - IDLE, accept of MULU/DIVU/REMU: load operands, counter=WIDTH, go to BUSY.
  - BUSY: one shift-add (MULU) or one restoring shift-subtract (DIVU/REMU) step per cycle; counter decrements each step. When the counter reaches 0, register result/zero and go to DONE. out_valid first goes high WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1. result and zero are held stable until out_ready is sampled high; then go to IDLE.
  - out_ready already high on DONE entry means handoff on the first DONE edge.
- Divide by zero (b==0): DIVU gives all ones; REMU gives a. This still takes the full WIDTH+1 latency so timing does not depend on data.
- zero is computed from the final registered result only and never toggles during BUSY.
- in_valid while busy is ignored, not queued. The producer must hold in_valid until in_ready.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_MULU, ALU_DIVU, ALU_REMU).
  - State encoding (ST_IDLE, ST_BUSY, ST_DONE).
  - Function is_multicycle(op).
- One sub-module, alu_muldiv_iter:
  - WIDTH-parameterised iterative engine with start, op, a, b inputs and done, res outputs.
  - Holds the accumulator/quotient/remainder registers and the counter.
- The top level keeps the FSM, handshake, single-cycle datapath and zero flag.

Test Plan (WIDTH=64 unless stated):
- Reset asserted mid-BUSY of DIVU (a=100, b=7), then deasserted -> immediately out_valid=0, in_ready=1, result=0, zero=1; the next op runs normally.
- ADD a=5, b=3, out_ready=1 -> out_valid high exactly one cycle after accept, result=8, zero=0; in_ready high the following cycle.
- SUB a=b=0x1234 -> result=0, zero=1. Opcode 1111 with a=b=0xFF -> result=0, zero=1.
- MULU a=0xFFFF_FFFF, b=0x1_0000_0001 -> out_valid at accept+65, result=0xFFFF_FFFF_FFFF_FFFF. MULU a=2^63, b=2 -> result=0, zero=1.
- DIVU a=100, b=7 -> 14; REMU -> 2. DIVU a=9, b=0 -> all ones; REMU a=9, b=0 -> 9. Latency is 65 cycles in every case.
- Backpressure: out_ready=0 for 10 cycles after completing OR a=0xF0, b=0x0F -> result=0xFF held, out_valid held, in_valid pulses ignored. Raising out_ready gives handoff at that edge; a new op with WIDTH=8 (second instance) completes MULU in 9 cycles.
